// File: rtl/alu_pipe_cc_pkg.sv
// Shared constants for the pipelined ALU: op codes, flag bit positions
// and the condition-code value loaded at reset.
package alu_pipe_cc_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    // Bit positions inside a {OF,SF,ZF} flag vector
    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    // Architectural CC after reset: ZF=1, SF=0, OF=0
    localparam logic [2:0] CC_RESET = 3'b001;

endpackage

// File: rtl/alu_pipe_cc_core.sv
// Combinational ALU used at pipeline entry. Produces a (WIDTH+1)-bit
// result whose top bit is the carry-out of the ADD/SUB chain, plus the
// {OF,SF,ZF} flags of that result.
module alu_core
    import alu_pipe_cc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic [WIDTH:0]          result,
    output logic [2:0]              flags
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;

    // SUB reuses the adder as A + ~B + 1, so bit WIDTH is 1 when no borrow
    always_comb begin
        b_eff = (op == ALU_SUB) ? ~b : b;
        cin   = (op == ALU_SUB);
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

        result = '0;
        case (op)
            ALU_ADD: result = sum;
            ALU_SUB: result = sum;
            ALU_AND: result = {1'b0, a & b};
            ALU_XOR: result = {1'b0, a ^ b};
            default: result = '0;
        endcase

        flags        = '0;
        flags[CC_ZF] = (result[WIDTH-1:0] == '0);
        flags[CC_SF] = result[WIDTH-1];
        if (op == ALU_ADD)
            flags[CC_OF] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        else if (op == ALU_SUB)
            flags[CC_OF] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_pipe_cc.sv
// Pipelined ALU with condition-code register. The value is computed at
// entry; the remaining DEPTH-1 stages only delay it. All stages advance
// together whenever the output slot is empty or being retired.
module alu_pipe_cc
    import alu_pipe_cc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic                    in_set_cc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH:0]          out_result,
    output logic [2:0]              out_flags,
    output logic [2:0]              cc
);

    logic           adv;
    logic [WIDTH:0] core_res;
    logic [2:0]     core_flg;

    logic           vld_p [DEPTH];
    logic [WIDTH:0] res_p [DEPTH];
    logic [2:0]     flg_p [DEPTH];
    logic           scc_p [DEPTH];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (core_res),
        .flags  (core_flg)
    );

    assign out_valid = vld_p[DEPTH-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && rst_n;

    // Data stages are not reset, so the presented value is masked by valid
    assign out_result = out_valid ? res_p[DEPTH-1] : '0;
    assign out_flags  = out_valid ? flg_p[DEPTH-1] : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_entry
            // Entry stage valid: takes a new operation (or a bubble) on advance
            always_ff @(posedge clk) begin
                if (!rst_n)
                    vld_p[0] <= 1'b0;
                else if (adv)
                    vld_p[0] <= in_valid;
            end

            // Entry stage data: captures the combinational ALU output
            always_ff @(posedge clk) begin
                if (adv) begin
                    res_p[0] <= core_res;
                    flg_p[0] <= core_flg;
                    scc_p[0] <= in_set_cc;
                end
            end
        end else begin : g_delay
            // Delay stage valid: shifts from the previous stage on advance
            always_ff @(posedge clk) begin
                if (!rst_n)
                    vld_p[i] <= 1'b0;
                else if (adv)
                    vld_p[i] <= vld_p[i-1];
            end

            // Delay stage data: shifts from the previous stage on advance
            always_ff @(posedge clk) begin
                if (adv) begin
                    res_p[i] <= res_p[i-1];
                    flg_p[i] <= flg_p[i-1];
                    scc_p[i] <= scc_p[i-1];
                end
            end
        end
    end

    // Condition codes change only when a set_cc result actually retires
    always_ff @(posedge clk) begin
        if (!rst_n)
            cc <= CC_RESET;
        else if (out_valid && out_ready && scc_p[DEPTH-1])
            cc <= out_flags;
    end

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Bench for alu_pipe_cc: a 64-bit/DEPTH=2 and a 16-bit/DEPTH=1 instance
// share one stimulus stream; each has its own in-order result queue model.
module tb_alu_pipe_cc;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_set_cc, out_ready;
    logic [1:0]  in_op;
    logic [63:0] in_a, in_b;

    logic        ir64, ov64;
    logic [64:0] res64;
    logic [2:0]  fl64, cc64;
    logic        ir16, ov16;
    logic [16:0] res16;
    logic [2:0]  fl16, cc16;

    alu_pipe_cc #(.WIDTH(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
        .out_valid(ov64), .out_ready(out_ready), .out_result(res64),
        .out_flags(fl64), .cc(cc64)
    );

    alu_pipe_cc #(.WIDTH(16), .DEPTH(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .in_op(in_op), .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_set_cc(in_set_cc),
        .out_valid(ov16), .out_ready(out_ready), .out_result(res16),
        .out_flags(fl16), .cc(cc16)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state per instance: pending results in order, and how many
    // advancing edges each has seen since it was accepted.
    logic [68:0] q   [2][$];
    int          age [2][$];
    logic [2:0]  mcc [2];
    int          acc_cnt [2];
    int          ret_cnt [2];
    bit          rst_seen [2];
    bit          armed = 1'b0;

    // Reference ALU: returns {OF,SF,ZF, carry, value} for operand width w
    function automatic logic [67:0] ref_op(input logic [1:0] op, input logic [63:0] a_in,
                                           input logic [63:0] b_in, input int w);
        logic [64:0] mask, a, b, full;
        logic [63:0] v;
        logic        c, zf, sf, of;
        mask = (65'd1 << w) - 65'd1;
        a = {1'b0, a_in} & mask;
        b = {1'b0, b_in} & mask;
        c = 1'b0;
        of = 1'b0;
        case (op)
            2'd0:    begin full = a + b;                  c = full[w]; end
            2'd1:    begin full = a + (~b & mask) + 65'd1; c = full[w]; end
            2'd2:    full = a & b;
            default: full = a ^ b;
        endcase
        v  = full[63:0] & mask[63:0];
        zf = (v == 64'd0);
        sf = v[w-1];
        if (op == 2'd0) of = (a[w-1] == b[w-1]) && (sf != a[w-1]);
        if (op == 2'd1) of = (a[w-1] != b[w-1]) && (sf != a[w-1]);
        return {of, sf, zf, c, v};
    endfunction

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model, then apply the coming edge to the model
    task automatic compare_and_update();
        logic [68:0] ent;
        logic [64:0] eres, ares;
        logic [2:0]  afl, acc;
        logic        air, aov;
        bit          mv, eir;
        int          d, w;
        for (int g = 0; g < 2; g++) begin
            d = (g == 0) ? 2 : 1;
            w = (g == 0) ? 64 : 16;
            if (g == 0) begin
                air = ir64; aov = ov64; ares = res64; afl = fl64; acc = cc64;
            end else begin
                air = ir16; aov = ov16; ares = {48'd0, res16}; afl = fl16; acc = cc16;
            end
            mv  = (q[g].size() > 0) && (age[g][0] == d - 1);
            eir = rst_n && (!mv || out_ready);
            if (armed) begin
                chk($sformatf("in_ready_w%0d", w), 68'(air), 68'(eir));
                chk($sformatf("out_valid_w%0d", w), 68'(aov), 68'(mv));
                chk($sformatf("cc_w%0d", w), 68'(acc), 68'(mcc[g]));
                if (mv) begin
                    ent  = q[g][0];
                    eres = (g == 0) ? ent[64:0] : {48'd0, ent[64], ent[15:0]};
                    chk($sformatf("out_result_w%0d", w), 68'(ares), 68'(eres));
                    chk($sformatf("out_flags_w%0d", w), 68'(afl), 68'(ent[67:65]));
                end
                if (rst_seen[g]) begin
                    chk($sformatf("post_reset_result_w%0d", w), 68'(ares), 68'd0);
                    chk($sformatf("post_reset_flags_w%0d", w), 68'(afl), 68'd0);
                end
            end
            rst_seen[g] = 1'b0;
            if (!rst_n) begin
                q[g].delete();
                age[g].delete();
                mcc[g]      = 3'b001;
                rst_seen[g] = 1'b1;
            end else begin
                if (mv && out_ready) begin
                    if (q[g][0][68]) mcc[g] = q[g][0][67:65];
                    void'(q[g].pop_front());
                    void'(age[g].pop_front());
                    ret_cnt[g]++;
                end
                if (!mv || out_ready) begin
                    for (int i = 0; i < age[g].size(); i++) age[g][i] = age[g][i] + 1;
                    if (in_valid) begin
                        q[g].push_back({in_set_cc, ref_op(in_op, in_a, in_b, w)});
                        age[g].push_back(0);
                        acc_cnt[g]++;
                    end
                end
            end
        end
        if (!rst_n) armed = 1'b1;
    endtask

    task automatic cyc();
        #1;
        compare_and_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic scc);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_set_cc = scc;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h0000_0000_0000_8000;
            5:       return 64'h0000_0000_0000_7FFF;
            6:       return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [67:0] m;
        int idx, abase, rbase, a0;
        logic [1:0]  bp_op [4];
        logic [63:0] bp_a  [4];
        logic [63:0] bp_b  [4];

        for (int g = 0; g < 2; g++) begin
            mcc[g] = 3'b001; acc_cnt[g] = 0; ret_cnt[g] = 0; rst_seen[g] = 1'b0;
        end

        // Pin the reference model with hand-computed values
        m = ref_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64);
        chk("model_add_ovf", m, {3'b110, 1'b0, 64'h8000_0000_0000_0000});
        m = ref_op(2'd1, 64'd5, 64'd5, 64);
        chk("model_sub_eq", m, {3'b001, 1'b1, 64'd0});
        m = ref_op(2'd1, 64'd0, 64'd1, 64);
        chk("model_sub_neg", m, {3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        m = ref_op(2'd0, 64'h7FFF, 64'd1, 16);
        chk("model_add16_ovf", m, {3'b110, 1'b0, 64'h8000});

        // Reset held two cycles while an operation is offered
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'd0, 64'd3, 64'd4, 1'b1);
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_in_ready64", 68'(ir64), 68'd0);
        chk("rst_out_valid64", 68'(ov64), 68'd0);
        chk("rst_cc64", 68'(cc64), 68'b001);
        chk("rst_in_ready16", 68'(ir16), 68'd0);
        chk("rst_cc16", 68'(cc16), 68'b001);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("rst_nothing_accepted", 68'(acc_cnt[0]), 68'd0);

        // Signed overflow on ADD
        drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        cyc();
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("ovf_result", 68'(res64), 68'h0_8000_0000_0000_0000);
        chk("ovf_flags", 68'(fl64), 68'b110);
        cyc();
        chk("ovf_cc", 68'(cc64), 68'b110);
        cyc();

        // SUB back to back: 5-5 then 0-1
        drive(1'b1, 2'd1, 64'd5, 64'd5, 1'b1);
        cyc();
        drive(1'b1, 2'd1, 64'd0, 64'd1, 1'b1);
        cyc();
        chk("sub_eq_valid", 68'(ov64), 68'd1);
        chk("sub_eq_result", 68'(res64), 68'h1_0000_0000_0000_0000);
        chk("sub_eq_zf", 68'(fl64[0]), 68'd1);
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("sub_neg_valid", 68'(ov64), 68'd1);
        chk("sub_neg_result", 68'(res64), 68'h0_FFFF_FFFF_FFFF_FFFF);
        chk("sub_neg_flags", 68'(fl64), 68'b010);
        cyc();
        cyc();

        // Backpressure: four offered operations, output blocked for a while
        bp_op[0] = 2'd0; bp_a[0] = 64'd10;  bp_b[0] = 64'd20;
        bp_op[1] = 2'd1; bp_a[1] = 64'd7;   bp_b[1] = 64'd9;
        bp_op[2] = 2'd3; bp_a[2] = 64'hAA;  bp_b[2] = 64'h0F;
        bp_op[3] = 2'd2; bp_a[3] = '1;      bp_b[3] = 64'h1234;
        idx = 0; abase = acc_cnt[0]; rbase = ret_cnt[0];
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) drive(1'b1, bp_op[idx], bp_a[idx], bp_b[idx], 1'b0);
            else         drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
            out_ready = (c >= 6);
            a0 = acc_cnt[0];
            cyc();
            if (acc_cnt[0] > a0) idx++;
            if (c == 5) begin
                chk("bp_accepted", 68'(acc_cnt[0] - abase), 68'd2);
                chk("bp_in_ready_low", 68'(ir64), 68'd0);
                chk("bp_result_held", 68'(res64), 68'({1'b0, 64'd30}));
            end
        end
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        chk("bp_retired", 68'(ret_cnt[0] - rbase), 68'd4);

        // Logic ops and set_cc gating
        chk("pre_and_cc", 68'(cc64), 68'b010);
        drive(1'b1, 2'd2, 64'hF0F0, 64'hFF00, 1'b0);
        cyc();
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("and_result", 68'(res64), 68'hF000);
        cyc();
        chk("and_cc_held", 68'(cc64), 68'b010);
        drive(1'b1, 2'd3, 64'h1234, 64'h1234, 1'b1);
        cyc();
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("xor_result", 68'(res64), 68'd0);
        chk("xor_flags", 68'(fl64), 68'b001);
        cyc();
        chk("xor_cc", 68'(cc64), 68'b001);

        // Reset with a full pipeline, after moving cc away from its reset value
        drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_7FFF, 64'd1, 1'b1);
        cyc();
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        cyc();
        cyc();
        chk("pre_rst_cc64", 68'(cc64), 68'b000);
        chk("pre_rst_cc16", 68'(cc16), 68'b110);
        out_ready = 1'b0;
        drive(1'b1, 2'd1, 64'd1, 64'd2, 1'b1);
        for (int c = 0; c < 3; c++) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
        chk("midrst_valid64", 68'(ov64), 68'd0);
        chk("midrst_cc64", 68'(cc64), 68'b001);
        chk("midrst_valid16", 68'(ov16), 68'd0);
        chk("midrst_cc16", 68'(cc16), 68'b001);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cyc();

        // Randomized traffic with random backpressure and occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 1)));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
